// File: rtl/nota_pkg.sv
// nota_pkg: shared constants for the note-sequence word classifier.
//   - 4-bit state encoding for the classifier FSM
//   - note codes carried on `nota` (X = wildcard/rest, DO..SI)
//   - result codes carried on `tipo`
//   - active-low 7-segment patterns {g,f,e,d,c,b,a}
package nota_pkg;

   localparam int unsigned STATE_W = 4;
   localparam int unsigned NOTA_W  = 3;
   localparam int unsigned TIPO_W  = 2;
   localparam int unsigned SEG_W   = 7;

   // FSM state encoding
   localparam logic [STATE_W-1:0] S_IDLE  = 4'd0;
   localparam logic [STATE_W-1:0] S_N1    = 4'd1;
   localparam logic [STATE_W-1:0] S_N2    = 4'd2;
   localparam logic [STATE_W-1:0] S_N3_LA = 4'd3;
   localparam logic [STATE_W-1:0] S_N3_SI = 4'd4;
   localparam logic [STATE_W-1:0] S_ADJ   = 4'd5;
   localparam logic [STATE_W-1:0] S_COMP  = 4'd6;
   localparam logic [STATE_W-1:0] S_ADV   = 4'd7;
   localparam logic [STATE_W-1:0] S_ERR   = 4'd8;

   // Note codes
   localparam logic [NOTA_W-1:0] NOTA_X   = 3'd0;
   localparam logic [NOTA_W-1:0] NOTA_DO  = 3'd1;
   localparam logic [NOTA_W-1:0] NOTA_RE  = 3'd2;
   localparam logic [NOTA_W-1:0] NOTA_MI  = 3'd3;
   localparam logic [NOTA_W-1:0] NOTA_FA  = 3'd4;
   localparam logic [NOTA_W-1:0] NOTA_SOL = 3'd5;
   localparam logic [NOTA_W-1:0] NOTA_LA  = 3'd6;
   localparam logic [NOTA_W-1:0] NOTA_SI  = 3'd7;

   // Result codes
   localparam logic [TIPO_W-1:0] TIPO_NULO = 2'b00;
   localparam logic [TIPO_W-1:0] TIPO_ADJ  = 2'b01;
   localparam logic [TIPO_W-1:0] TIPO_COMP = 2'b10;
   localparam logic [TIPO_W-1:0] TIPO_ADV  = 2'b11;

   // Active-low segment patterns {g,f,e,d,c,b,a}
   localparam logic [SEG_W-1:0] SEG_0    = 7'b1000000;
   localparam logic [SEG_W-1:0] SEG_1    = 7'b1111001;
   localparam logic [SEG_W-1:0] SEG_2    = 7'b0100100;
   localparam logic [SEG_W-1:0] SEG_3    = 7'b0110000;
   localparam logic [SEG_W-1:0] SEG_A    = 7'b0001000;
   localparam logic [SEG_W-1:0] SEG_C    = 7'b1000110;
   localparam logic [SEG_W-1:0] SEG_D    = 7'b0100001;
   localparam logic [SEG_W-1:0] SEG_E    = 7'b0000110;
   localparam logic [SEG_W-1:0] SEG_DASH = 7'b0111111;

   // True while a word is partially entered (the states the timeout guards)
   function automatic logic is_in_word(input logic [STATE_W-1:0] s);
      return (s == S_N1) || (s == S_N2) || (s == S_N3_LA) || (s == S_N3_SI);
   endfunction

   // True once a word has produced a result or been rejected
   function automatic logic is_terminal(input logic [STATE_W-1:0] s);
      return (s == S_ADJ) || (s == S_COMP) || (s == S_ADV) || (s == S_ERR);
   endfunction

   // Wildcard note: matches regardless of the sharp flag
   function automatic logic is_wild(input logic [NOTA_W-1:0] n);
      return n == NOTA_X;
   endfunction

endpackage

// File: rtl/ok_sync_edge.sv
// ok_sync_edge: brings the asynchronous `din` strobe into the clk domain
// through a SYNC_STAGES-deep flop chain and emits a registered one-cycle
// `pulse` on each synchronised rising edge.
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   asynchronous, active-high
//   din    in   asynchronous strobe
//   pulse  out  one-cycle pulse, SYNC_STAGES+1 edges after din is first sampled high
module ok_sync_edge #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic pulse
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_last;
   logic                   w_synced;

   assign w_synced = r_sync[SYNC_STAGES-1];

   // Synchroniser chain, delayed copy for edge detection, registered pulse
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync <= '0;
         r_last <= 1'b0;
         pulse  <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], din};
         r_last <= w_synced;
         pulse  <= w_synced & ~r_last;
      end
   end

endmodule

// File: rtl/nota_classificador.sv
// nota_classificador: classifies a word of notes, one note per `ok` strobe.
// Recognised words (x = wildcard, # = sharp):
//   x x la x | x x si x -> adjective   x x la do# | x x si re# -> comparative
//   x x la si           -> adverb      anything else / timeout  -> error
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   asynchronous, active-high
//   ok       in   asynchronous note strobe (one note per rising edge)
//   tom      in   1 = sharp, 0 = natural
//   nota     in   0 = x, 1..7 = do..si
//   fim      out  word finished (result or error)
//   tipo     out  00 nulo, 01 adj, 10 comp, 11 adv
//   erro     out  word rejected
//   display  out  {g,f,e,d,c,b,a} active-low: progress digit or result letter
module nota_classificador
   import nota_pkg::*;
#(
   parameter int unsigned SYNC_STAGES  = 2,
   parameter int unsigned TIMEOUT      = 1000,
   parameter bit          AUTO_RESTART = 1'b0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ok,
   input  logic              tom,
   input  logic [NOTA_W-1:0] nota,
   output logic              fim,
   output logic [TIPO_W-1:0] tipo,
   output logic              erro,
   output logic [SEG_W-1:0]  display
);

   // A zero TIMEOUT still needs a one-bit counter to keep the declarations legal
   localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   logic [STATE_W-1:0] r_state;
   logic [STATE_W-1:0] w_state_next;
   logic [CNT_W-1:0]   r_cnt;
   logic               w_ok_evt;
   logic               w_in_word;
   logic               w_timeout;
   logic               w_is_x;
   logic               w_fim;
   logic [TIPO_W-1:0]  w_tipo;
   logic               w_erro;
   logic [SEG_W-1:0]   w_display;

   // Synchronised, edge-detected note strobe
   ok_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_ok_sync_edge (
      .clk   (clk),
      .reset (reset),
      .din   (ok),
      .pulse (w_ok_evt)
   );

   assign w_in_word = is_in_word(r_state);
   assign w_is_x    = is_wild(nota);

   // Expiry only matters without a note in the same cycle; the note wins
   assign w_timeout = (TIMEOUT != 0) && w_in_word && (r_cnt == CNT_W'(TIMEOUT));

   // Inter-note timeout counter: runs only while a word is partially entered
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (w_ok_evt || !w_in_word || (TIMEOUT == 0)) begin
         r_cnt <= '0;
      end else if (!w_timeout) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   // State register and registered outputs (decoded from the next state)
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         fim     <= 1'b0;
         tipo    <= TIPO_NULO;
         erro    <= 1'b0;
         display <= SEG_0;
      end else begin
         r_state <= w_state_next;
         fim     <= w_fim;
         tipo    <= w_tipo;
         erro    <= w_erro;
         display <= w_display;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_ok_evt) begin
               w_state_next = w_is_x ? S_N1 : S_ERR;
            end
         end
         S_N1: begin
            if (w_ok_evt) begin
               w_state_next = w_is_x ? S_N2 : S_ERR;
            end else if (w_timeout) begin
               w_state_next = S_ERR;
            end
         end
         S_N2: begin
            if (w_ok_evt) begin
               if (!tom && (nota == NOTA_LA)) begin
                  w_state_next = S_N3_LA;
               end else if (!tom && (nota == NOTA_SI)) begin
                  w_state_next = S_N3_SI;
               end else begin
                  w_state_next = S_ERR;
               end
            end else if (w_timeout) begin
               w_state_next = S_ERR;
            end
         end
         S_N3_LA: begin
            if (w_ok_evt) begin
               if (w_is_x) begin
                  w_state_next = S_ADJ;
               end else if (tom && (nota == NOTA_DO)) begin
                  w_state_next = S_COMP;
               end else if (!tom && (nota == NOTA_SI)) begin
                  w_state_next = S_ADV;
               end else begin
                  w_state_next = S_ERR;
               end
            end else if (w_timeout) begin
               w_state_next = S_ERR;
            end
         end
         S_N3_SI: begin
            if (w_ok_evt) begin
               if (w_is_x) begin
                  w_state_next = S_ADJ;
               end else if (tom && (nota == NOTA_RE)) begin
                  w_state_next = S_COMP;
               end else begin
                  w_state_next = S_ERR;
               end
            end else if (w_timeout) begin
               w_state_next = S_ERR;
            end
         end
         S_ADJ, S_COMP, S_ADV, S_ERR: begin
            // Results hold; with auto-restart a note starts a new word as from IDLE
            if (AUTO_RESTART && w_ok_evt) begin
               w_state_next = w_is_x ? S_N1 : S_ERR;
            end
         end
         default: begin
            w_state_next = S_ERR;
         end
      endcase
   end

   // Output decode of the state being entered
   always_comb begin
      w_fim     = 1'b0;
      w_tipo    = TIPO_NULO;
      w_erro    = 1'b0;
      w_display = SEG_0;
      case (w_state_next)
         S_IDLE: begin
            w_display = SEG_0;
         end
         S_N1: begin
            w_display = SEG_1;
         end
         S_N2: begin
            w_display = SEG_2;
         end
         S_N3_LA, S_N3_SI: begin
            w_display = SEG_3;
         end
         S_ADJ: begin
            w_fim     = 1'b1;
            w_tipo    = TIPO_ADJ;
            w_display = SEG_A;
         end
         S_COMP: begin
            w_fim     = 1'b1;
            w_tipo    = TIPO_COMP;
            w_display = SEG_C;
         end
         S_ADV: begin
            w_fim     = 1'b1;
            w_tipo    = TIPO_ADV;
            w_display = SEG_D;
         end
         S_ERR: begin
            w_fim     = 1'b1;
            w_erro    = 1'b1;
            w_display = SEG_E;
         end
         default: begin
            w_display = SEG_DASH;
         end
      endcase
   end

endmodule

// File: tb/tb_nota_classificador.sv
// tb_nota_classificador: three instances share one stimulus stream:
//   dut 0: SYNC_STAGES 2, TIMEOUT 8, AUTO_RESTART 0
//   dut 1: SYNC_STAGES 2, TIMEOUT 8, AUTO_RESTART 1
//   dut 2: SYNC_STAGES 3, TIMEOUT 0, AUTO_RESTART 0
// Each instance is compared against a word-table reference model.
module tb_nota_classificador;

   localparam logic [6:0] D0 = 7'b1000000;
   localparam logic [6:0] D1 = 7'b1111001;
   localparam logic [6:0] D2 = 7'b0100100;
   localparam logic [6:0] D3 = 7'b0110000;
   localparam logic [6:0] DA = 7'b0001000;
   localparam logic [6:0] DC = 7'b1000110;
   localparam logic [6:0] DD = 7'b0100001;
   localparam logic [6:0] DE = 7'b0000110;

   logic       clk;
   logic       reset;
   logic       ok;
   logic       tom;
   logic [2:0] nota;

   logic       fim_w  [3];
   logic [1:0] tipo_w [3];
   logic       erro_w [3];
   logic [6:0] disp_w [3];

   int n_checks;
   int n_fail;
   int cyc;

   // Accepted words: note codes, sharp flags (ignored for x), resulting tipo
   int vw_n [5][4] = '{'{0, 0, 6, 0}, '{0, 0, 7, 0}, '{0, 0, 6, 1}, '{0, 0, 7, 2}, '{0, 0, 6, 7}};
   bit vw_t [5][4] = '{'{0, 0, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 1}, '{0, 0, 0, 1}, '{0, 0, 0, 0}};
   int vw_r [5]    = '{1, 1, 2, 2, 3};

   // Model state per instance
   int       m_len  [3];
   bit       m_term [3];
   bit       m_err  [3];
   int       m_tipo [3];
   int       m_last [3];
   int       m_wn   [3][4];
   bit       m_wt   [3][4];

   nota_classificador #(.SYNC_STAGES(2), .TIMEOUT(8), .AUTO_RESTART(1'b0)) u_dut0 (
      .clk(clk), .reset(reset), .ok(ok), .tom(tom), .nota(nota),
      .fim(fim_w[0]), .tipo(tipo_w[0]), .erro(erro_w[0]), .display(disp_w[0]));
   nota_classificador #(.SYNC_STAGES(2), .TIMEOUT(8), .AUTO_RESTART(1'b1)) u_dut1 (
      .clk(clk), .reset(reset), .ok(ok), .tom(tom), .nota(nota),
      .fim(fim_w[1]), .tipo(tipo_w[1]), .erro(erro_w[1]), .display(disp_w[1]));
   nota_classificador #(.SYNC_STAGES(3), .TIMEOUT(0), .AUTO_RESTART(1'b0)) u_dut2 (
      .clk(clk), .reset(reset), .ok(ok), .tom(tom), .nota(nota),
      .fim(fim_w[2]), .tipo(tipo_w[2]), .erro(erro_w[2]), .display(disp_w[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int s_of(input int i);
      return (i == 2) ? 3 : 2;
   endfunction

   function automatic int t_of(input int i);
      return (i == 2) ? 0 : 8;
   endfunction

   function automatic bit auto_of(input int i);
      return i == 1;
   endfunction

   function automatic bit note_ok(input int tn, input bit tt, input int n, input bit t);
      return (tn == 0) ? (n == 0) : ((n == tn) && (t == tt));
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   task automatic model_clear(input int i);
      m_len[i]  = 0;
      m_term[i] = 0;
      m_err[i]  = 0;
      m_tipo[i] = 0;
      m_last[i] = 0;
   endtask

   task automatic model_fail(input int i);
      m_term[i] = 1;
      m_err[i]  = 1;
      m_tipo[i] = 0;
   endtask

   // A word in progress is rejected if no note arrives within T+1 cycles of the last one
   task automatic model_timeout(input int i, input int now);
      if (t_of(i) != 0 && !m_term[i] && m_len[i] > 0 && now > m_last[i] + t_of(i) + 1)
         model_fail(i);
   endtask

   task automatic model_event(input int i, input int n, input bit t, input int ecyc);
      bit prefix;
      int res;
      model_timeout(i, ecyc);
      if (m_term[i]) begin
         if (!auto_of(i)) return;
         model_clear(i);
      end
      m_wn[i][m_len[i]] = n;
      m_wt[i][m_len[i]] = t;
      m_len[i]++;
      m_last[i] = ecyc;
      prefix = 0;
      res    = 0;
      for (int w = 0; w < 5; w++) begin
         bit match;
         match = 1;
         for (int k = 0; k < m_len[i]; k++)
            if (!note_ok(vw_n[w][k], vw_t[w][k], m_wn[i][k], m_wt[i][k])) match = 0;
         if (match) begin
            prefix = 1;
            if (m_len[i] == 4) res = vw_r[w];
         end
      end
      if (!prefix) model_fail(i);
      else if (m_len[i] == 4) begin
         m_term[i] = 1;
         m_tipo[i] = res;
      end
   endtask

   function automatic logic [6:0] exp_disp(input int i);
      if (!m_term[i]) begin
         case (m_len[i])
            0:       return D0;
            1:       return D1;
            2:       return D2;
            default: return D3;
         endcase
      end
      if (m_err[i]) return DE;
      case (m_tipo[i])
         1:       return DA;
         2:       return DC;
         default: return DD;
      endcase
   endfunction

   task automatic check_all(input string tag);
      for (int i = 0; i < 3; i++) begin
         model_timeout(i, cyc);
         check_eq($sformatf("%s[%0d].fim", tag, i), 32'(fim_w[i]), 32'(m_term[i]));
         check_eq($sformatf("%s[%0d].tipo", tag, i), 32'(tipo_w[i]), 32'(m_tipo[i]));
         check_eq($sformatf("%s[%0d].erro", tag, i), 32'(erro_w[i]), 32'(m_err[i]));
         check_eq($sformatf("%s[%0d].display", tag, i), 32'(disp_w[i]), 32'(exp_disp(i)));
      end
   endtask

   // One note: ok high for hi cycles, low for lo cycles; event lands S+1 cycles after the rise
   task automatic send(input int n, input bit t, input int hi, input int lo);
      int k;
      nota = 3'(n);
      tom  = t;
      ok   = 1'b1;
      k    = cyc;
      for (int i = 0; i < 3; i++) model_event(i, n, t, k + s_of(i) + 1);
      tick(hi);
      ok = 1'b0;
      tick(lo);
   endtask

   task automatic do_reset();
      #2;
      reset = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) model_clear(i);
      check_eq("reset_async_disp", 32'(disp_w[0]), 32'(D0));
      check_all("reset");
      tick(2);
      reset = 1'b0;
      tick(1);
   endtask

   initial begin
      int k;
      int pick;
      int n;
      bit t;
      n_checks = 0;
      n_fail   = 0;
      cyc      = 0;
      reset    = 1'b1;
      ok       = 1'b0;
      tom      = 1'b0;
      nota     = 3'd0;
      for (int i = 0; i < 3; i++) model_clear(i);
      #1;
      check_all("por");
      tick(2);
      reset = 1'b0;
      tick(1);

      // Event latency per synchroniser depth, then x x la x -> adjective
      nota = 3'd0;
      tom  = 1'b0;
      ok   = 1'b1;
      k    = cyc;
      for (int i = 0; i < 3; i++) model_event(i, 0, 0, k + s_of(i) + 1);
      tick(3);
      check_eq("lat_s2_before", 32'(disp_w[0]), 32'(D0));
      tick(1);
      check_eq("lat_s2_after", 32'(disp_w[0]), 32'(D1));
      check_eq("lat_s3_before", 32'(disp_w[2]), 32'(D0));
      tick(1);
      check_eq("lat_s3_after", 32'(disp_w[2]), 32'(D1));
      ok = 1'b0;
      tick(4);
      check_all("adj1");
      send(0, 0, 4, 4);
      check_eq("adj_step2", 32'(disp_w[0]), 32'(D2));
      check_all("adj2");
      send(6, 0, 4, 4);
      check_eq("adj_step3", 32'(disp_w[0]), 32'(D3));
      check_all("adj3");
      send(0, 1, 4, 4);
      check_eq("adj_tipo", 32'(tipo_w[0]), 32'd1);
      check_eq("adj_disp", 32'(disp_w[0]), 32'(DA));
      check_all("adj4");

      do_reset();
      send(0, 0, 4, 4); send(0, 0, 4, 4); send(6, 0, 4, 4); send(1, 1, 4, 4);
      check_eq("comp_la_tipo", 32'(tipo_w[0]), 32'd2);
      check_all("comp_la");

      do_reset();
      send(0, 0, 4, 4); send(0, 0, 4, 4); send(7, 0, 4, 4); send(2, 1, 4, 4);
      check_eq("comp_si_tipo", 32'(tipo_w[0]), 32'd2);
      check_all("comp_si");

      // Adverb, then one more x: auto-restart starts a word, others hold
      do_reset();
      send(0, 0, 4, 4); send(0, 0, 4, 4); send(6, 0, 4, 4); send(7, 0, 4, 4);
      check_eq("adv_tipo", 32'(tipo_w[0]), 32'd3);
      check_eq("adv_disp", 32'(disp_w[0]), 32'(DD));
      check_all("adv");
      send(0, 0, 4, 4);
      check_eq("auto_fim", 32'(fim_w[1]), 32'd0);
      check_eq("auto_disp", 32'(disp_w[1]), 32'(D1));
      check_eq("hold_tipo", 32'(tipo_w[0]), 32'd3);
      check_all("auto");

      do_reset();
      send(0, 0, 4, 4); send(1, 0, 4, 4);
      check_eq("err_do_erro", 32'(erro_w[0]), 32'd1);
      check_eq("err_do_disp", 32'(disp_w[0]), 32'(DE));
      check_all("err_do");

      do_reset();
      send(0, 0, 4, 4); send(0, 0, 4, 4); send(6, 1, 4, 4);
      check_eq("err_lash", 32'(erro_w[0]), 32'd1);
      check_all("err_lash");

      // Timeout: still in progress on the expiry cycle, rejected one cycle later
      do_reset();
      send(0, 0, 4, 4); send(0, 0, 4, 4);
      tick(4);
      check_eq("to_edge_erro", 32'(erro_w[0]), 32'd0);
      check_all("to_edge");
      tick(1);
      check_eq("to_hit_erro", 32'(erro_w[0]), 32'd1);
      check_eq("to_off_disp", 32'(disp_w[2]), 32'(D2));
      check_all("to_hit");

      // A note landing exactly on the expiry cycle is accepted
      do_reset();
      send(0, 0, 4, 4); send(0, 0, 4, 5); send(6, 0, 4, 4); send(0, 0, 4, 4);
      check_eq("to_race_tipo", 32'(tipo_w[0]), 32'd1);
      check_all("to_race");

      // Reset in the middle of a word
      do_reset();
      send(0, 0, 4, 4); send(0, 0, 4, 4);
      check_eq("mid_pre", 32'(disp_w[0]), 32'(D2));
      do_reset();

      // Held ok produces a single note
      send(0, 0, 50, 5);
      check_eq("held_disp", 32'(disp_w[2]), 32'(D1));
      check_all("held");
      do_reset();

      // Randomised words, mostly drawn from the accepted table
      for (int w = 0; w < 40; w++) begin
         pick = $urandom_range(0, 4);
         for (int j = 0; j < 4; j++) begin
            if ($urandom_range(0, 7) != 0) begin
               n = vw_n[pick][j];
               t = (n == 0) ? 1'($urandom_range(0, 1)) : vw_t[pick][j];
            end else begin
               n = $urandom_range(0, 7);
               t = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 7) == 0) send(n, t, 4, 4 + $urandom_range(1, 4));
            else                           send(n, t, 4, 4 + $urandom_range(0, 1));
            check_all("rnd");
         end
         if ($urandom_range(0, 1) != 0) do_reset();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
